// File: rtl/hist_pkg.sv
// Shared types and per-channel sizing for the HSV histogram frame controllers.
package hist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACCUM   = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_READOUT = 3'd4
  } hist_state_e;

  localparam int HIST_CNT_W    = 32;
  localparam int HIST_BIN_AW_H = 9;
  localparam int HIST_BIN_AW_S = 9;
  localparam int HIST_BIN_AW_V = 8;

endpackage

// File: rtl/hist_rd_stage.sv
// Port-B read return path: delays the issue strobe by the RAM latency and holds
// the returned bin count until the downstream handshake completes.
module hist_rd_stage
  import hist_pkg::*;
#(
  parameter int CNT_W  = HIST_CNT_W,
  parameter int RD_LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_i,
  input  logic [CNT_W-1:0] rd_data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [CNT_W-1:0] data_o
);

  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic              hold_q, hold_d;
  logic [CNT_W-1:0]  data_q, data_d;
  logic              arrive;

  always_comb begin
    vld_pipe_d = (vld_pipe_q << 1) | RD_LAT'(issue_i);
    arrive     = vld_pipe_q[RD_LAT-1];
    // Returning data goes straight out; it is only parked when the beat stalls.
    data_d     = arrive ? rd_data_i : data_q;
    hold_d     = hold_q ? ~ready_i : (arrive & ~ready_i);
    valid_o    = arrive | hold_q;
    data_o     = hold_q ? data_q : (arrive ? rd_data_i : '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe_q <= '0;
      hold_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      hold_q     <= hold_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: rtl/histogram_frame_ctrl.sv
// Per-channel histogram frame sequencer: clear sweep, gated accumulation,
// RMW drain, then valid/ready readout of every bin on RAM port B.
module histogram_frame_ctrl
  import hist_pkg::*;
#(
  parameter int BIN_AW  = 9,
  parameter int CNT_W   = HIST_CNT_W,
  parameter int RD_LAT  = 1,
  parameter int ACC_LAT = 2
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              vsync_i,
  input  logic              de_i,
  output logic              acc_en_o,
  output logic [BIN_AW-1:0] ram_b_addr_o,
  output logic              ram_b_wr_en_o,
  input  logic [CNT_W-1:0]  ram_b_rd_data_i,
  output logic              bin_valid_o,
  input  logic              bin_ready_i,
  output logic [CNT_W-1:0]  bin_data_o,
  output logic [BIN_AW-1:0] bin_idx_o,
  output logic              bin_last_o,
  output logic              busy_o,
  output logic              drop_o
);

  localparam int DW = $clog2(ACC_LAT + 1);

  hist_state_e       state_q, state_d;
  logic [BIN_AW-1:0] addr_q, addr_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              vsync_q;
  logic              abort_q, abort_d;
  logic              pend_q, pend_d;
  logic              drop_q, drop_d;
  logic              rise, fall, addr_last, hs, issue;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    drain_d   = drain_q;
    abort_d   = abort_q;
    pend_d    = pend_q;
    issue     = 1'b0;
    rise      = vsync_i & ~vsync_q;
    fall      = ~vsync_i & vsync_q;
    addr_last = &addr_q;
    hs        = bin_valid_o & bin_ready_i;
    drop_d    = rise & (state_q == ST_CLEAR || state_q == ST_DRAIN || state_q == ST_READOUT);
    case (state_q)
      ST_IDLE: if (rise) begin
        state_d = ST_CLEAR;
        addr_d  = '0;
        abort_d = 1'b0;
      end
      ST_CLEAR: begin
        // An early frame end still finishes the sweep so the RAM is left clean.
        addr_d = addr_q + BIN_AW'(1);
        if (fall) abort_d = 1'b1;
        if (addr_last) state_d = (abort_q | fall) ? ST_IDLE : ST_ACCUM;
      end
      ST_ACCUM: if (fall) begin
        state_d = ST_DRAIN;
        drain_d = DW'(ACC_LAT);
      end
      ST_DRAIN: begin
        if (drain_q <= DW'(1)) begin
          state_d = ST_READOUT;
          addr_d  = '0;
          pend_d  = 1'b0;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      ST_READOUT: begin
        // Single outstanding read: addr_q stays put until its beat is taken.
        issue = ~pend_q;
        if (issue) pend_d = 1'b1;
        if (hs) begin
          pend_d = 1'b0;
          addr_d = addr_q + BIN_AW'(1);
          if (addr_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      drain_q <= '0;
      vsync_q <= 1'b0;
      abort_q <= 1'b0;
      pend_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      vsync_q <= vsync_i;
      abort_q <= abort_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  hist_rd_stage #(.CNT_W(CNT_W), .RD_LAT(RD_LAT)) u_rd (
    .clk_i     (sys_clk_i),
    .rst_i     (sys_rst_i),
    .issue_i   (issue),
    .rd_data_i (ram_b_rd_data_i),
    .ready_i   (bin_ready_i),
    .valid_o   (bin_valid_o),
    .data_o    (bin_data_o)
  );

  assign acc_en_o      = (state_q == ST_ACCUM) & de_i;
  assign ram_b_wr_en_o = (state_q == ST_CLEAR);
  assign ram_b_addr_o  = addr_q;
  assign bin_idx_o     = bin_valid_o ? addr_q : '0;
  assign bin_last_o    = bin_valid_o & addr_last;
  assign busy_o        = (state_q != ST_IDLE);
  assign drop_o        = drop_q;

endmodule
